// File: rtl/line_draw_ctrl.sv
// Bresenham line sequencer: one endpoint pair in, one pixel coordinate out per handshake.
// Optional build macro LINE_CLIP_EN: steps off-screen pixels silently instead of emitting them.
module line_draw_ctrl #(
  parameter int WIDTH = 13,
  parameter int XMAX  = 639,
  parameter int YMAX  = 479
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] y1,
  input  logic                    abort,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic signed [WIDTH-1:0] pix_x,
  output logic signed [WIDTH-1:0] pix_y,
  output logic                    pix_last,
  output logic                    done,
  output logic                    busy
);

  localparam int EW  = WIDTH + 2;
  localparam int E2W = WIDTH + 3;

  typedef logic signed [WIDTH-1:0] coord_t;
  typedef logic signed [EW-1:0]    ext_t;
  typedef logic signed [E2W-1:0]   e2_t;

`ifdef LINE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam coord_t ONE  = coord_t'(1);
  localparam coord_t XLIM = coord_t'(XMAX);
  localparam coord_t YLIM = coord_t'(YMAX);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

  state_t state_q, state_d;
  coord_t cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  coord_t end_x_q, end_x_d, end_y_q, end_y_d;
  ext_t   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic   sxn_q, sxn_d, syn_q, syn_d;
  logic   done_q, done_d;

  ext_t   diff_x, diff_y;
  e2_t    e2;
  logic   step_x, step_y, at_end, vis_cur, vis_nxt, adv;
  coord_t nx, ny;

  function automatic logic in_box(input coord_t x, input coord_t y);
    return !x[WIDTH-1] && (x <= XLIM) && !y[WIDTH-1] && (y <= YLIM);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      end_x_q <= '0;
      end_y_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      end_x_q <= end_x_d;
      end_y_q <= end_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      done_q  <= done_d;
    end
  end

  // Visible pixels of a monotonic line form one contiguous run, so "last visible"
  // is decided by looking one Bresenham step ahead.
  always_comb begin
    diff_x  = ext_t'(end_x_q) - ext_t'(cur_x_q);
    diff_y  = ext_t'(end_y_q) - ext_t'(cur_y_q);
    e2      = e2_t'(err_q) <<< 1;
    step_x  = (e2 >= e2_t'(dy_q));
    step_y  = (e2 <= e2_t'(dx_q));
    nx      = step_x ? (sxn_q ? cur_x_q - ONE : cur_x_q + ONE) : cur_x_q;
    ny      = step_y ? (syn_q ? cur_y_q - ONE : cur_y_q + ONE) : cur_y_q;
    at_end  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
    vis_cur = !CLIP_EN || in_box(cur_x_q, cur_y_q);
    vis_nxt = !CLIP_EN || in_box(nx, ny);
    adv     = (state_q == S_DRAW) && (!vis_cur || pix_ready);

    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    end_x_d = end_x_q;
    end_y_d = end_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cur_x_d = x0;
          cur_y_d = y0;
          end_x_d = x1;
          end_y_d = y1;
        end
      end
      S_SETUP: begin
        dx_d   = diff_x[EW-1] ? -diff_x : diff_x;
        dy_d   = diff_y[EW-1] ? diff_y : -diff_y;
        sxn_d  = !(cur_x_q < end_x_q);
        syn_d  = !(cur_y_q < end_y_q);
        err_d  = dx_d + dy_d;
        done_d = abort;
      end
      S_DRAW: begin
        if (abort) begin
          done_d = 1'b1;
        end else if (adv) begin
          if (at_end) begin
            done_d = 1'b1;
          end else begin
            cur_x_d = nx;
            cur_y_d = ny;
            err_d   = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_SETUP;
      S_SETUP: state_d = abort ? S_IDLE : S_DRAW;
      S_DRAW:  if (abort || (adv && at_end)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    pix_valid = (state_q == S_DRAW) && vis_cur;
    pix_last  = pix_valid && (at_end || !vis_nxt);
    pix_x     = cur_x_q;
    pix_y     = cur_y_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_line_draw_ctrl.sv
// Directed bench for line_draw_ctrl: expected pixels are queued when a line is issued
// and checked in order as the DUT hands them over.
module tb_line_draw_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic signed [12:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic abort = 1'b0;
  logic pix_valid, pix_ready = 1'b0, pix_last, done, busy;
  logic signed [12:0] pix_x, pix_y;

  typedef struct packed {
    logic signed [12:0] x;
    logic signed [12:0] y;
    logic               last;
  } pix_t;

  pix_t exp_q[$];
  pix_t got;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  int d0;

  line_draw_ctrl #(.WIDTH(13), .XMAX(639), .YMAX(479)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .abort(abort),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Pixels accepted during an abort cycle are discarded by the DUT, so they are not scored.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pix_valid && pix_ready && !abort) begin
        if (exp_q.size() == 0) begin
          chk("pix_unexpected", 1, 0);
        end else begin
          got = exp_q.pop_front();
          chk("pix_x", pix_x, got.x);
          chk("pix_y", pix_y, got.y);
          chk("pix_last", pix_last, got.last);
          if (pix_last) last_cyc = cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y, input bit last);
    pix_t p;
    p.x = 13'(x);
    p.y = 13'(y);
    p.last = last;
    exp_q.push_back(p);
  endtask

  task automatic send_line(input int ax, input int ay, input int bx, input int by);
    chk("in_ready_idle", in_ready, 1);
    x0 = 13'(ax);
    y0 = 13'(ay);
    x1 = 13'(bx);
    y1 = 13'(by);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_last", pix_last, 0);
    chk("rst_pix_x", pix_x, 0);
    step();

    // horizontal line, latency and done timing
    pix_ready = 1'b1;
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 0, 1);
    d0 = done_cnt;
    send_line(0, 0, 3, 0);
    @(negedge clk);
    chk("lat_setup_valid", pix_valid, 0);
    chk("lat_setup_busy", busy, 1);
    @(negedge clk);
    chk("lat_draw_valid", pix_valid, 1);
    wait_done("horiz");
    step();
    chk("horiz_done_delay", done_cyc - last_cyc, 1);
    chk("horiz_done_count", done_cnt - d0, 1);
    @(negedge clk);
    chk("horiz_done_width", done, 0);
    step();

    push(0, 0, 0); push(0, 1, 0); push(1, 2, 0); push(1, 3, 1);
    send_line(0, 0, 1, 3);
    wait_done("steep");
    step();

    push(2, 2, 0); push(1, 1, 0); push(0, 0, 1);
    send_line(2, 2, 0, 0);
    wait_done("negdiag");
    step();

    d0 = done_cnt;
    push(5, 5, 1);
    send_line(5, 5, 5, 5);
    wait_done("degen");
    step();
    chk("degen_done_count", done_cnt - d0, 1);

    // backpressure: hold (1,0) for three cycles
    pix_ready = 1'b0;
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 0, 1);
    send_line(0, 0, 3, 0);
    step();
    pix_ready = 1'b1;
    step();
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", pix_valid, 1);
      chk("stall_x", pix_x, 1);
      chk("stall_last", pix_last, 0);
      step();
    end
    pix_ready = 1'b1;
    wait_done("stall");
    step();

    // abort while pixel (2,0) is pending
    push(0, 0, 0); push(1, 0, 0);
    send_line(0, 0, 3, 0);
    step(); step(); step();
    abort = 1'b1;
    pix_ready = 1'b0;
    @(negedge clk);
    chk("abort_pending_x", pix_x, 2);
    d0 = done_cnt;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", pix_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_in_ready", in_ready, 1);
    step();
    chk("abort_queue_empty", exp_q.size(), 0);
    chk("abort_done_count", done_cnt - d0, 1);

    // abort coinciding with the final pixel handshake
    pix_ready = 1'b1;
    d0 = done_cnt;
    send_line(5, 5, 5, 5);
    step();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_last_pix_last", pix_last, 1);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_last_valid", pix_valid, 0);
    step(); step();
    chk("abort_last_done_count", done_cnt - d0, 1);

    // abort in IDLE is ignored
    d0 = done_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("idle_abort_ready", in_ready, 1);
    chk("idle_abort_done_count", done_cnt - d0, 0);

    // reset mid-line
    pix_ready = 1'b0;
    send_line(0, 0, 3, 0);
    step();
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_valid", pix_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pix_x", pix_x, 0);
    step();
    rst = 1'b0;
    step(); step();
    chk("midrst_done_count", done_cnt - d0, 0);

    // line starting off-screen to the left
    pix_ready = 1'b1;
    d0 = done_cnt;
`ifdef LINE_CLIP_EN
    push(0, 0, 0); push(1, 0, 1);
`else
    push(-2, 0, 0); push(-1, 0, 0); push(0, 0, 0); push(1, 0, 1);
`endif
    send_line(-2, 0, 1, 0);
    wait_done("clip");
    step();
    chk("clip_done_count", done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
